// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch sequencer:
//     PC_W      program counter / fetch address width
//     INSTR_W   instruction word width
//     TO_W      width of the FETCH timeout counter
//     state_e   sequencer FSM states
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int PC_W    = 15;
   localparam int INSTR_W = 32;
   localparam int TO_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_EXEC,
      ST_HALTED,
      ST_ERROR
   } state_e;

endpackage : fetch_pkg

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//   Instruction-memory request bus between the sequencer and the memory.
//     imem_req    request, high for the whole FETCH state (sequencer -> mem)
//     imem_addr   fetch address                           (sequencer -> mem)
//     imem_ready  data valid this cycle                   (mem -> sequencer)
//     imem_rdata  instruction word, valid with imem_ready (mem -> sequencer)
//   Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_sequencer_if
   import fetch_pkg::*;
();

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface : fetch_sequencer_if

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC select applied when the execute stage finishes.
//   Priority: halt (hold pc) > jump_taken (jump_target) > pc+1.
//   The increment wraps modulo 2^PC_W with no overflow indication.
//     pc_i          current program counter
//     halt_i        current instruction is a halt
//     jump_taken_i  current instruction redirects
//     jump_target_i redirect address
//     pc_next_o     selected next program counter
// ---------------------------------------------------------------------------
module pc_next_sel
   import fetch_pkg::*;
(
   input  logic [PC_W-1:0] pc_i,
   input  logic            halt_i,
   input  logic            jump_taken_i,
   input  logic [PC_W-1:0] jump_target_i,
   output logic [PC_W-1:0] pc_next_o
);

   always_comb begin
      if (halt_i) begin
         pc_next_o = pc_i;
      end else if (jump_taken_i) begin
         pc_next_o = jump_target_i;
      end else begin
         // Carry out of the top bit is dropped, giving 7FFF -> 0000.
         pc_next_o = pc_i + PC_W'(1);
      end
   end

endmodule : pc_next_sel

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Sequences instruction fetch and execute handshakes:
//   IDLE -> FETCH -> WAIT_EXEC -> FETCH ... until HALTED or ERROR (timeout).
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     start         begin execution from pc (IDLE only)
//     imem          instruction-memory bus (master side)
//     ex_done       execute stage finished (WAIT_EXEC only)
//     jump_taken, jump_target, halt   sampled with ex_done
//     instr         last fetched instruction
//     instr_valid   one-cycle pulse when instr updates
//     pc            program counter (also drives imem_addr)
//     busy          high in FETCH or WAIT_EXEC
//     error         high in ERROR
// ---------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 15'd0,
   parameter int unsigned     TIMEOUT  = 16     // legal range 1..255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   fetch_sequencer_if.master  imem,
   input  logic               ex_done,
   input  logic               jump_taken,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               halt,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [PC_W-1:0]    pc,
   output logic               busy,
   output logic               error
);

   localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic [TO_W-1:0]    cnt_q, cnt_d;
   logic [PC_W-1:0]    pc_next;

   pc_next_sel u_pc_next_sel (
      .pc_i          (pc_q),
      .halt_i        (halt),
      .jump_taken_i  (jump_taken),
      .jump_target_i (jump_target),
      .pc_next_o     (pc_next)
   );

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      cnt_d         = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               cnt_d   = '0;
            end
         end
         ST_FETCH: begin
            // A ready in the same cycle the counter would hit TIMEOUT wins.
            if (imem.imem_ready) begin
               instr_d       = imem.imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = ST_WAIT_EXEC;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
               if (cnt_d == TIMEOUT_C) begin
                  state_d = ST_ERROR;
               end
            end
         end
         ST_WAIT_EXEC: begin
            if (ex_done) begin
               pc_d = pc_next;
               if (halt) begin
                  state_d = ST_HALTED;
               end else begin
                  state_d = ST_FETCH;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            // HALTED and ERROR are left only through rst.
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         cnt_q         <= cnt_d;
      end
   end

   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign instr_valid    = instr_valid_q;
   assign pc             = pc_q;
   assign busy           = (state_q == ST_FETCH) || (state_q == ST_WAIT_EXEC);
   assign error          = (state_q == ST_ERROR);

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed stimulus against fetch_sequencer (TIMEOUT=4). A behavioural
//   model tracks the sequencer's mode, pc, instruction and fetch wait time;
//   one compare process checks every output on each falling edge, and the
//   stimulus adds literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam logic [PC_W-1:0] RESET_PC = 15'd0;
   localparam int              TIMEOUT  = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               ex_done;
   logic               jump_taken;
   logic [PC_W-1:0]    jump_target;
   logic               halt;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [PC_W-1:0]    pc;
   logic               busy;
   logic               error;

   fetch_sequencer_if imem_bus ();

   fetch_sequencer #(
      .RESET_PC (RESET_PC),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .imem        (imem_bus),
      .ex_done     (ex_done),
      .jump_taken  (jump_taken),
      .jump_target (jump_target),
      .halt        (halt),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .error       (error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_FETCH = 1, M_WAIT = 2, M_HALTED = 3, M_ERROR = 4;

   int          m_mode  = M_IDLE;
   int          m_pc    = 0;
   logic [31:0] m_instr = '0;
   bit          m_valid = 1'b0;
   int          m_waits = 0;     // FETCH cycles spent without imem_ready
   bit          m_live  = 1'b0;  // model is meaningful once reset was seen

   always @(posedge clk) begin
      if (rst) begin
         m_mode  = M_IDLE;
         m_pc    = int'(RESET_PC);
         m_instr = '0;
         m_valid = 1'b0;
         m_waits = 0;
         m_live  = 1'b1;
      end else begin
         m_valid = 1'b0;
         if (m_mode == M_IDLE) begin
            if (start) begin
               m_mode  = M_FETCH;
               m_waits = 0;
            end
         end else if (m_mode == M_FETCH) begin
            if (imem_bus.imem_ready) begin
               m_instr = imem_bus.imem_rdata;
               m_valid = 1'b1;
               m_mode  = M_WAIT;
            end else begin
               m_waits = m_waits + 1;
               if (m_waits >= TIMEOUT) m_mode = M_ERROR;
            end
         end else if (m_mode == M_WAIT) begin
            if (ex_done) begin
               if (halt) begin
                  m_mode = M_HALTED;
               end else begin
                  m_pc    = jump_taken ? int'(jump_target) : (m_pc + 1) % 32768;
                  m_mode  = M_FETCH;
                  m_waits = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc_pc",          32'(pc),                 32'(m_pc));
         check("cyc_imem_addr",   32'(imem_bus.imem_addr), 32'(m_pc));
         check("cyc_imem_req",    32'(imem_bus.imem_req),  32'(m_mode == M_FETCH));
         check("cyc_busy",        32'(busy),               32'(m_mode == M_FETCH || m_mode == M_WAIT));
         check("cyc_error",       32'(error),              32'(m_mode == M_ERROR));
         check("cyc_instr",       instr,                   m_instr);
         check("cyc_instr_valid", 32'(instr_valid),        32'(m_valid));
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_inputs();
      start                = 1'b0;
      ex_done              = 1'b0;
      jump_taken           = 1'b0;
      jump_target          = '0;
      halt                 = 1'b0;
      imem_bus.imem_ready  = 1'b0;
      imem_bus.imem_rdata  = '0;
   endtask

   // Advance n rising edges; returns 1 time unit after the last edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fetch_now(input logic [31:0] word);
      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = word;
      tick();
      imem_bus.imem_ready = 1'b0;
   endtask

   task automatic exec_done(input bit h, input bit j, input logic [PC_W-1:0] tgt);
      ex_done     = 1'b1;
      halt        = h;
      jump_taken  = j;
      jump_target = tgt;
      tick();
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      check("reset_pc",    32'(pc), 32'(RESET_PC));
      check("reset_instr", instr, 32'h0);
      check("reset_busy",  32'(busy), 32'd0);

      // Spurious imem_ready in IDLE.
      fetch_now(32'h1111_2222);
      check("idle_ready_instr", instr, 32'h0);
      check("idle_ready_busy",  32'(busy), 32'd0);

      // Start, two FETCH cycles without ready, then capture.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_req", 32'(imem_bus.imem_req), 32'd1);
      tick(2);
      fetch_now(32'hDEAD_BEEF);
      check("cap_instr", instr, 32'hDEAD_BEEF);
      check("cap_valid", 32'(instr_valid), 32'd1);

      // Spurious imem_ready and start in WAIT_EXEC.
      start = 1'b1;
      fetch_now(32'h1234_5678);
      start = 1'b0;
      check("wait_ready_instr", instr, 32'hDEAD_BEEF);
      check("wait_ready_valid", 32'(instr_valid), 32'd0);

      // ex_done without jump: pc 0 -> 1 and FETCH again.
      exec_done(1'b0, 1'b0, 15'h0);
      check("inc_pc",  32'(pc), 32'd1);
      check("inc_req", 32'(imem_bus.imem_req), 32'd1);

      // Spurious ex_done in FETCH.
      exec_done(1'b0, 1'b1, 15'h0555);
      check("fetch_exdone_pc",  32'(pc), 32'd1);
      check("fetch_exdone_req", 32'(imem_bus.imem_req), 32'd1);

      // Jump redirect.
      fetch_now(32'hA5A5_0001);
      exec_done(1'b0, 1'b1, 15'h0123);
      check("jump_addr", 32'(imem_bus.imem_addr), 32'h0123);

      // Wrap from 7FFF.
      fetch_now(32'hA5A5_0002);
      exec_done(1'b0, 1'b1, 15'h7FFF);
      check("pre_wrap_pc", 32'(pc), 32'h7FFF);
      fetch_now(32'hA5A5_0003);
      exec_done(1'b0, 1'b0, 15'h0);
      check("wrap_pc", 32'(pc), 32'h0000);

      // Ready arrives on the 4th FETCH cycle (TIMEOUT=4): capture wins.
      tick(3);
      fetch_now(32'hCAFE_F00D);
      check("edge_error", 32'(error), 32'd0);
      check("edge_instr", instr, 32'hCAFE_F00D);

      // Halt beats jump; pc unchanged; start ignored afterwards.
      exec_done(1'b1, 1'b1, 15'h0222);
      check("halt_pc",   32'(pc), 32'h0000);
      check("halt_busy", 32'(busy), 32'd0);
      start = 1'b1;
      tick(2);
      start = 1'b0;
      check("halt_start_req", 32'(imem_bus.imem_req), 32'd0);

      // Timeout: four FETCH cycles without ready -> ERROR.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(3);
      check("to_pre_error", 32'(error), 32'd0);
      tick();
      check("to_error", 32'(error), 32'd1);
      check("to_busy",  32'(busy), 32'd0);
      start = 1'b1;
      fetch_now(32'h0BAD_0BAD);
      start = 1'b0;
      check("error_sticky", 32'(error), 32'd1);

      // Reset mid-WAIT_EXEC at pc 0x42, together with ex_done.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch_now(32'h0000_0042);
      exec_done(1'b0, 1'b1, 15'h0042);
      fetch_now(32'h4242_4242);
      check("pre_rst_pc", 32'(pc), 32'h0042);
      rst     = 1'b1;
      ex_done = 1'b1;
      tick();
      rst     = 1'b0;
      ex_done = 1'b0;
      check("rst_pc",    32'(pc), 32'(RESET_PC));
      check("rst_instr", instr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_req",   32'(imem_bus.imem_req), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 15'd0: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: maximum FETCH cycles without imem_ready before ERROR; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin execution from current PC; sampled only in IDLE.
REQ-006 imem_ready  input  1  instruction memory data valid this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid with imem_ready.
REQ-008 ex_done  input  1  execute stage finished current instruction.
REQ-009 jump_taken  input  1  current instruction redirects PC; sampled with ex_done.
REQ-010 jump_target  input  15  redirect address; sampled with ex_done.
REQ-011 halt  input  1  current instruction is a halt; sampled with ex_done.
REQ-012 imem_req  output  1  fetch request, held high for the whole FETCH state.
REQ-013 imem_addr  output  15  fetch address, equals pc.
REQ-014 instr  output  32  last fetched instruction, held until the next capture.
REQ-015 instr_valid  output  1  one-cycle pulse when instr updates.
REQ-016 pc  output  15  current program counter.
REQ-017 busy  output  1  high in FETCH or WAIT_EXEC.
REQ-018 error  output  1  high in ERROR.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, WAIT_EXEC, HALTED, ERROR; all outputs registered or decoded directly from state.
REQ-020 IDLE: start=1 -> FETCH next cycle; otherwise stay.
REQ-021 FETCH: imem_req=1, imem_addr=pc; imem_ready=1 -> capture imem_rdata into instr, pulse instr_valid next cycle, go to WAIT_EXEC.
REQ-022 FETCH timeout: an 8-bit counter clears on FETCH entry and increments each FETCH cycle without imem_ready; reaching TIMEOUT -> ERROR.
REQ-023 imem_ready in the cycle the counter reaches TIMEOUT SHALL win: capture proceeds, no ERROR.
REQ-024 WAIT_EXEC: ex_done=1 -> if halt, go to HALTED with pc unchanged; else pc <= jump_taken ? jump_target : pc+1 and go to FETCH.
REQ-025 Priority on ex_done: halt > jump_taken > increment.
REQ-026 pc+1 SHALL wrap modulo 2^15 (15'h7FFF -> 15'h0000) with no flag.
REQ-027 Latency: start at cycle t -> imem_req high at t+1; imem_ready at t -> instr_valid at t+1; ex_done at t -> new pc and imem_req at t+1.
REQ-028 start outside IDLE, imem_ready outside FETCH, and ex_done outside WAIT_EXEC SHALL be ignored.
REQ-029 HALTED and ERROR are terminal; only rst exits them.

Reset
REQ-030 rst=1 at any edge, including mid-FETCH or mid-WAIT_EXEC, SHALL force IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, busy=0, error=0, timeout counter=0.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the state enum, PC_W=15, INSTR_W=32 and TO_W=8.
REQ-033 Next-PC selection (halt/jump/increment mux with wrap) SHALL be one combinational sub-module, pc_next_sel; the FSM, counter and registers stay in fetch_sequencer.

Verification
REQ-034 Reset, start, imem_ready after 2 cycles with 32'hDEADBEEF, then ex_done with no jump -> instr=32'hDEADBEEF, one instr_valid pulse, pc 0 -> 1, FETCH re-entered.
REQ-035 pc=15'h7FFF, ex_done with no jump -> pc=15'h0000.
REQ-036 ex_done with jump_taken=1, jump_target=15'h0123 -> imem_addr=15'h0123 next cycle; ex_done with halt=1 and jump_taken=1 -> HALTED, pc unchanged, start ignored.
REQ-037 TIMEOUT=4, no imem_ready -> error=1 after 4 FETCH cycles; repeat with imem_ready on cycle 4 -> no error, instruction captured.
REQ-038 rst pulsed mid-WAIT_EXEC at pc=15'h0042 -> next cycle IDLE, pc=RESET_PC, all outputs 0.
REQ-039 Spurious imem_ready in IDLE/WAIT_EXEC and ex_done in FETCH -> no state, pc or instr change.
